hb_decim_cascade: RTL and testbench
===================================

HB_DECIM_CASCADE -- requirements
Module: hb_decim_cascade

Interface
REQ-001 Parameter DATA_WIDTH, default 24: input, internal stage and output sample width, two's complement.
REQ-002 Parameter COEFF_WIDTH, default 18: signed coefficient width, Q(COEFF_WIDTH-1) format.
REQ-003 Parameter NUM_STAGES, default 3: number of cascaded 2x halfband stages, range 1..6.
REQ-004 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-005 Parameters C_OUTER/C_INNER/C_CENTER, defaults -6144/38912/65536: taps h0=h6, h2=h4, h3; h1=h5=0.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 in_valid  input  1  in_data is a new sample this cycle; there is no backpressure on input.
REQ-009 in_data  input  DATA_WIDTH  signed input sample.
REQ-010 mode  input  clog2(NUM_STAGES+1)  number of active stages: 0 = bypass; values above NUM_STAGES clamp to NUM_STAGES.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_valid  output  1  FIFO not empty.
REQ-013 out_data  output  DATA_WIDTH  FIFO head sample.
REQ-014 ovf_flag  output  1  sticky; set by any stage arithmetic overflow.
REQ-015 drop_flag  output  1  sticky; set when a sample is lost because the FIFO is full.

Function
REQ-016 Stage k SHALL take its input from stage k-1 (stage 0 from in_valid/in_data) and keep a 7-deep delay line plus a 1-bit phase toggle.
REQ-017 A stage SHALL emit one output per two accepted inputs, on the odd-indexed (2nd, 4th, ...) accepted sample since flush: y = h0*x[n]+h2*x[n-2]+h3*x[n-3]+h4*x[n-4]+h6*x[n-6].
REQ-018 The accumulator SHALL be at least DATA_WIDTH+COEFF_WIDTH+2 bits.
REQ-019 Scaling: add 2^(COEFF_WIDTH-2), then arithmetic right shift by COEFF_WIDTH-1, then reduce to DATA_WIDTH.
REQ-020 Each stage output SHALL be registered, with stage out_valid high for exactly one cycle, one cycle after the triggering input.
REQ-021 Only the first M=mode stages are in the path; the last active stage (or the input, when M=0) writes the FIFO.
REQ-022 Latency from the triggering in_valid cycle to out_valid SHALL be M+1 cycles when the FIFO is empty and not stalled.
REQ-023 FIFO pop occurs when out_valid && out_ready; a simultaneous push and pop when full SHALL succeed with no drop.
REQ-024 A push into a full FIFO with no pop SHALL discard the new sample, keep the FIFO contents unchanged and set drop_flag.
REQ-025 When mode differs from the registered active mode, the block SHALL flush for one cycle: clear all delay lines, phases and the FIFO, and ignore in_valid that cycle.
REQ-026 After the flush cycle, the new mode applies from the next cycle.
REQ-027 Overflow is detected when the scaled result does not fit DATA_WIDTH; ovf_flag is then set.

Reset
REQ-028 While rst_n is low: out_valid=0, out_data=0, ovf_flag=0, drop_flag=0, FIFO empty, delay lines zero, phases even, active mode = clamped mode.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered samples immediately.
REQ-030 Sticky flags SHALL clear only on reset.

Configuration
REQ-031 With HB_SAT_EN defined, an overflowing stage result SHALL clamp to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
REQ-032 Without HB_SAT_EN, an overflowing result SHALL wrap (low DATA_WIDTH bits kept); ovf_flag behaves identically in both builds.

Verification
REQ-033 DC gain: mode=3, in_data=1000 on every cycle, out_ready=1 -> after settling every out_data=1000, one output per 8 inputs.
REQ-034 Impulse: mode=1, inputs idx1=131072, all others 0 -> outputs -6144, 38912, 38912, -6144, then 0.
REQ-035 Saturation: mode=1, x1=x7=-8388608, x3=x4=x5=8388607, others 0 -> 8th-sample output 8388607 with HB_SAT_EN, wrapped negative without it; ovf_flag=1 in both builds.
REQ-036 Backpressure: mode=0, out_ready=0, 6 inputs -> FIFO holds the first 4, drop_flag=1; raising out_ready returns those 4 in order.
REQ-037 Mode change: mode 2->1 mid-stream -> one ignored input cycle, FIFO emptied, next output after 2 new inputs.
REQ-038 Reset mid-stream: assert rst_n=0 with 3 FIFO entries -> out_valid=0 immediately and both flags 0.

Source files
------------

// File: rtl/hb_decim_cascade.sv
// Cascade of 2x halfband decimators with a mode-selected tap point feeding an output FIFO.
// Define HB_SAT_EN to saturate overflowing stage results instead of wrapping them.
module hb_decim_cascade #(
  parameter int DATA_WIDTH  = 24,
  parameter int COEFF_WIDTH = 18,
  parameter int NUM_STAGES  = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int C_OUTER     = -6144,
  parameter int C_INNER     = 38912,
  parameter int C_CENTER    = 65536,
  parameter int MODE_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ovf_flag,
  output logic                  drop_flag
);

  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic signed [ACC_W-1:0] K_OUT = ACC_W'(C_OUTER);
  localparam logic signed [ACC_W-1:0] K_IN  = ACC_W'(C_INNER);
  localparam logic signed [ACC_W-1:0] K_CEN = ACC_W'(C_CENTER);
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (COEFF_WIDTH - 2);
  localparam logic signed [ACC_W-1:0] MAXV  =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV  =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [MODE_W-1:0] mode_c;
  logic [MODE_W-1:0] active_reg;
  logic              flush;

  logic                         stg_in_valid [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] stg_in_data  [NUM_STAGES];
  logic                         st_valid     [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] st_data      [NUM_STAGES];
  logic [NUM_STAGES-1:0]        ovf_evt;

  assign mode_c = (mode > MODE_W'(NUM_STAGES)) ? MODE_W'(NUM_STAGES) : mode;
  assign flush  = (mode_c != active_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_reg <= mode_c;
    else        active_reg <= mode_c;
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    // Incoming sample plus six registered taps form the 7-sample window.
    logic signed [DATA_WIDTH-1:0] dl_reg [6];
    logic                         phase_reg;
    logic                         valid_reg;
    logic signed [DATA_WIDTH-1:0] data_reg;
    logic signed [ACC_W-1:0]      acc, rnd, shf;
    logic signed [DATA_WIDTH-1:0] res;
    logic                         ovf, acc_en, emit;

    if (gi == 0) begin : g_src_in
      assign stg_in_valid[gi] = in_valid && !flush;
      assign stg_in_data[gi]  = in_data;
    end else begin : g_src_prev
      assign stg_in_valid[gi] = st_valid[gi-1];
      assign stg_in_data[gi]  = st_data[gi-1];
    end

    assign acc_en = stg_in_valid[gi] && (int'(active_reg) > gi) && !flush;
    assign emit   = acc_en && phase_reg;

    always_comb begin
      acc = ACC_W'(stg_in_data[gi]) * K_OUT
          + ACC_W'(dl_reg[1]) * K_IN
          + ACC_W'(dl_reg[2]) * K_CEN
          + ACC_W'(dl_reg[3]) * K_IN
          + ACC_W'(dl_reg[5]) * K_OUT;
      rnd = acc + RND;
      shf = rnd >>> (COEFF_WIDTH - 1);
      ovf = (shf > MAXV) || (shf < MINV);
`ifdef HB_SAT_EN
      if (ovf) res = shf[ACC_W-1] ? MINV[DATA_WIDTH-1:0] : MAXV[DATA_WIDTH-1:0];
      else     res = shf[DATA_WIDTH-1:0];
`else
      res = shf[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 6; i++) dl_reg[i] <= '0;
        phase_reg <= 1'b0;
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (flush) begin
        for (int i = 0; i < 6; i++) dl_reg[i] <= '0;
        phase_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= emit;
        if (acc_en) begin
          dl_reg[0] <= stg_in_data[gi];
          for (int i = 1; i < 6; i++) dl_reg[i] <= dl_reg[i-1];
          phase_reg <= ~phase_reg;
          if (phase_reg) data_reg <= res;
        end
      end
    end

    assign st_valid[gi] = valid_reg;
    assign st_data[gi]  = data_reg;
    assign ovf_evt[gi]  = emit && ovf;
  end

  // FIFO source: raw input when bypassed, otherwise the last active stage.
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    push      = in_valid && !flush;
    push_data = in_data;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (active_reg == MODE_W'(i + 1)) begin
        push      = st_valid[i];
        push_data = st_data[i];
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_reg, rd_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  full, pop, wr_en, drop;

  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;
  assign wr_en = push && (!full || pop) && !flush;
  assign drop  = push && full && !pop && !flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg    <= '0;
      rd_reg    <= '0;
      count_reg <= '0;
      ovf_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      ovf_flag  <= ovf_flag | (|ovf_evt);
      drop_flag <= drop_flag | drop;
      if (flush) begin
        wr_reg    <= '0;
        rd_reg    <= '0;
        count_reg <= '0;
      end else begin
        if (pop)   rd_reg <= rd_reg + PTR_W'(1);
        if (wr_en) wr_reg <= wr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(pop);
      end
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? mem[rd_reg] : '0;

endmodule

// File: tb/tb_hb_decim_cascade.sv
// Directed bench for hb_decim_cascade: impulse table, DC gain, overflow, FIFO
// backpressure, mode-change flush and asynchronous reset.
module tb_hb_decim_cascade;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [23:0] in_data;
  logic [1:0]         mode;
  logic               out_ready;
  logic               out_valid;
  logic signed [23:0] out_data;
  logic               ovf_flag;
  logic               drop_flag;

  int checks   = 0;
  int failures = 0;
  int got[$];

  typedef struct {
    logic signed [23:0] din;
    bit                 has_out;
    int                 dout;
  } vec_t;

  vec_t tbl[10];

  hb_decim_cascade dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ovf_flag  (ovf_flag),
    .drop_flag (drop_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got.push_back(int'(out_data));
      $display("out transaction: data=%0d", out_data);
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_n    = 1'b0;
    mode     = m;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
  endtask

  initial begin
    tbl[0] = '{din: 0,      has_out: 0, dout: 0};
    tbl[1] = '{din: 131072, has_out: 1, dout: -6144};
    tbl[2] = '{din: 0,      has_out: 0, dout: 0};
    tbl[3] = '{din: 0,      has_out: 1, dout: 38912};
    tbl[4] = '{din: 0,      has_out: 0, dout: 0};
    tbl[5] = '{din: 0,      has_out: 1, dout: 38912};
    tbl[6] = '{din: 0,      has_out: 0, dout: 0};
    tbl[7] = '{din: 0,      has_out: 1, dout: -6144};
    tbl[8] = '{din: 0,      has_out: 0, dout: 0};
    tbl[9] = '{din: 0,      has_out: 1, dout: 0};

    // Reset state
    out_ready = 1'b1;
    rst_n     = 1'b0;
    mode      = 2'd1;
    in_valid  = 1'b0;
    in_data   = '0;
    #13;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data",  32'(out_data), 0);
    chk("reset_ovf",       32'(ovf_flag), 0);
    chk("reset_drop",      32'(drop_flag), 0);
    do_reset(2'd1);

    // Impulse response through one stage, with latency probes
    begin
      int exp_q[$];
      for (int i = 0; i < 10; i++) begin
        send(tbl[i].din);
        if (tbl[i].has_out) exp_q.push_back(tbl[i].dout);
        if (i == 1) chk("lat_m1_not_yet", 32'(out_valid), 0);
        if (i == 2) chk("lat_m1_valid",   32'(out_valid), 1);
      end
      idle(4);
      chk("impulse_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk($sformatf("impulse_out%0d", i), got[i], exp_q[i]);
    end

    // Overflow on the 8th sample
    do_reset(2'd1);
    begin
      logic signed [23:0] sat_in [8];
      int sat_exp;
      sat_in = '{0, -8388608, 0, 8388607, 8388607, 8388607, 0, -8388608};
`ifdef HB_SAT_EN
      sat_exp = 8388607;
`else
      sat_exp = -6815745;
`endif
      for (int i = 0; i < 8; i++) send(sat_in[i]);
      idle(4);
      chk("sat_count", got.size(), 4);
      if (got.size() == 4) begin
        chk("sat_out0", got[0], 393216);
        chk("sat_out3", got[3], sat_exp);
      end
      chk("sat_ovf_flag", 32'(ovf_flag), 1);
    end

    // Bypass with backpressure: 6 pushes into a 4-entry FIFO
    mode      = 2'd0;
    out_ready = 1'b0;
    idle(1);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      send(24'(11 + i));
      if (i == 0) chk("lat_m0_valid", 32'(out_valid), 1);
    end
    chk("bp_drop_flag", 32'(drop_flag), 1);
    chk("bp_head", 32'(out_data), 11);
    out_ready = 1'b1;
    idle(6);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_out%0d", i), got[i], 11 + i);
    chk("sticky_ovf", 32'(ovf_flag), 1);
    chk("sticky_drop", 32'(drop_flag), 1);

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    send(21); send(22); send(23);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_data",  32'(out_data), 0);
    chk("rst_mid_ovf",   32'(ovf_flag), 0);
    chk("rst_mid_drop",  32'(drop_flag), 0);

    // Push and pop together while full must not drop
    do_reset(2'd0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(24'(i));
    out_ready = 1'b1;
    send(5);
    idle(6);
    chk("full_pp_drop", 32'(drop_flag), 0);
    chk("full_pp_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("full_pp_out%0d", i), got[i], i + 1);

    // DC gain through three stages
    do_reset(2'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(1000);
    idle(8);
    chk("dc_count", got.size(), 8);
    for (int i = 5; i < 8 && i < got.size(); i++)
      chk($sformatf("dc_out%0d", i), got[i], 1000);
    chk("dc_ovf", 32'(ovf_flag), 0);

    // Mode change 2 -> 1 with buffered outputs
    do_reset(2'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(500);
    idle(3);
    chk("mc_pre_valid", 32'(out_valid), 1);
    mode = 2'd1;
    send(777);
    chk("mc_flushed", 32'(out_valid), 0);
    send(0);
    chk("mc_after_a0", 32'(out_valid), 0);
    send(131072);
    idle(1);
    chk("mc_new_valid", 32'(out_valid), 1);
    chk("mc_new_data", 32'(out_data), -6144);
    out_ready = 1'b1;
    idle(1);
    chk("mc_single_entry", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
